// File: rtl/gift_128_in_ctrl.sv
// Input controller for the GIFT-128 core: packs 32-bit key/data words into 128-bit blocks and
// issues key_ld / enc_start. Define GIFT_IN_CTRL_WDOG_EN to enable the response watchdog.
module gift_128_in_ctrl #(
    parameter int unsigned WDOG_CYCLES = 63
) (
    input  logic         clk_i,
    input  logic         reset_n,
    input  logic [31:0]  s_word,
    input  logic         s_is_key,
    input  logic         s_valid,
    output logic         s_ready,
    output logic         key_ld,
    output logic [127:0] key_in,
    output logic         enc_start,
    output logic [127:0] data_in,
    input  logic         key_process_done_latch,
    input  logic         cipher_done,
    output logic         key_ready,
    output logic         seq_err,
    output logic         err_wdog
);
    typedef enum logic [1:0] {StIdle, StKeyWait, StEncWait} state_e;

    state_e       r_state, w_state_d;
    logic [1:0]   r_wcnt, w_wcnt_d;
    logic [95:0]  r_asm, w_asm_d;
    logic         r_asm_tag, w_asm_tag_d;
    logic [127:0] r_pend, w_pend_d;
    logic         r_pend_tag, w_pend_tag_d;
    logic         r_pend_valid, w_pend_valid_d;
    logic         r_key_ready, w_key_ready_d;
    logic         r_seq_err, w_seq_err_d;
    logic         w_accept, w_mismatch, w_blk_done, w_drop, w_resp, w_wdog_trip;

    if (WDOG_CYCLES < 42 || WDOG_CYCLES > 63) begin : g_bad_wdog
        $error("WDOG_CYCLES must be in 42..63");
    end

    // ---------------------------------------------------------------- word assembly
    assign s_ready    = !(r_pend_valid && (r_wcnt == 2'd3));
    assign w_accept   = s_valid && s_ready;
    assign w_mismatch = w_accept && (r_wcnt != 2'd0) && (s_is_key != r_asm_tag);
    assign w_blk_done = w_accept && !w_mismatch && (r_wcnt == 2'd3);

    // Older words shift out of the top, so a restarted block needs no explicit clear.
    always_comb begin
        w_wcnt_d    = r_wcnt;
        w_asm_d     = r_asm;
        w_asm_tag_d = r_asm_tag;
        if (w_accept) begin
            w_asm_d = {r_asm[63:0], s_word};
            if (w_mismatch) begin
                w_wcnt_d    = 2'd1;
                w_asm_tag_d = s_is_key;
            end else begin
                w_wcnt_d = r_wcnt + 2'd1;
                if (r_wcnt == 2'd0) begin
                    w_asm_tag_d = s_is_key;
                end
            end
        end
    end

    // A completing block takes priority over the clear from issue/drop.
    always_comb begin
        w_pend_d       = r_pend;
        w_pend_tag_d   = r_pend_tag;
        w_pend_valid_d = r_pend_valid;
        if (key_ld || enc_start || w_drop) begin
            w_pend_valid_d = 1'b0;
        end
        if (w_blk_done) begin
            w_pend_d       = {r_asm, s_word};
            w_pend_tag_d   = r_asm_tag;
            w_pend_valid_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------- watchdog
`ifdef GIFT_IN_CTRL_WDOG_EN
    localparam logic [5:0] WdogLast = 6'(WDOG_CYCLES - 1);

    logic [5:0] r_wdog;
    logic       r_err_wdog;

    assign w_wdog_trip = (r_state != StIdle) && !w_resp && (r_wdog == WdogLast);
    assign err_wdog    = r_err_wdog;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog     <= 6'd0;
            r_err_wdog <= 1'b0;
        end else begin
            r_wdog <= (r_state == StIdle) ? 6'd0 : r_wdog + 6'd1;
            if (w_wdog_trip) begin
                r_err_wdog <= 1'b1;
            end
        end
    end
`else
    assign w_wdog_trip = 1'b0;
    assign err_wdog    = 1'b0;
`endif

    // ---------------------------------------------------------------- sequencer FSM
    assign w_resp = ((r_state == StKeyWait) && key_process_done_latch) ||
                    ((r_state == StEncWait) && cipher_done);

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (r_pend_valid && r_pend_tag) begin
                    w_state_d = StKeyWait;
                end else if (r_pend_valid && r_key_ready) begin
                    w_state_d = StEncWait;
                end
            end
            StKeyWait: begin
                if (key_process_done_latch || w_wdog_trip) begin
                    w_state_d = StIdle;
                end
            end
            StEncWait: begin
                if (cipher_done || w_wdog_trip) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Issue strobes decode from registers only; the core's busy flag is deliberately unused.
    always_comb begin
        key_ld    = 1'b0;
        enc_start = 1'b0;
        w_drop    = 1'b0;
        if ((r_state == StIdle) && r_pend_valid) begin
            if (r_pend_tag) begin
                key_ld = 1'b1;
            end else if (r_key_ready) begin
                enc_start = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    always_comb begin
        w_key_ready_d = r_key_ready;
        if (key_ld) begin
            w_key_ready_d = 1'b0;
        end else if ((r_state == StKeyWait) && key_process_done_latch) begin
            w_key_ready_d = 1'b1;
        end else if (w_wdog_trip) begin
            w_key_ready_d = 1'b0;
        end
    end

    assign w_seq_err_d = w_mismatch || w_drop;

    // ---------------------------------------------------------------- state registers
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_wcnt       <= 2'd0;
            r_asm        <= 96'd0;
            r_asm_tag    <= 1'b0;
            r_pend       <= 128'd0;
            r_pend_tag   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_key_ready  <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_wcnt       <= w_wcnt_d;
            r_asm        <= w_asm_d;
            r_asm_tag    <= w_asm_tag_d;
            r_pend       <= w_pend_d;
            r_pend_tag   <= w_pend_tag_d;
            r_pend_valid <= w_pend_valid_d;
            r_key_ready  <= w_key_ready_d;
            r_seq_err    <= w_seq_err_d;
        end
    end

    assign key_in    = r_pend;
    assign data_in   = r_pend;
    assign key_ready = r_key_ready;
    assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_gift_128_in_ctrl.sv
// Bench for gift_128_in_ctrl: directed word streams, a small GIFT core timing model and a
// queue of expected key_ld / enc_start / seq_err events checked by a separate monitor.
module tb_gift_128_in_ctrl;
    logic         clk_i = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  s_word = 32'd0;
    logic         s_is_key = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         key_ld;
    logic [127:0] key_in;
    logic         enc_start;
    logic [127:0] data_in;
    logic         key_process_done_latch;
    logic         cipher_done;
    logic         key_ready;
    logic         seq_err;
    logic         err_wdog;

    gift_128_in_ctrl dut (
        .clk_i                  (clk_i),
        .reset_n                (reset_n),
        .s_word                 (s_word),
        .s_is_key               (s_is_key),
        .s_valid                (s_valid),
        .s_ready                (s_ready),
        .key_ld                 (key_ld),
        .key_in                 (key_in),
        .enc_start              (enc_start),
        .data_in                (data_in),
        .key_process_done_latch (key_process_done_latch),
        .cipher_done            (cipher_done),
        .key_ready              (key_ready),
        .seq_err                (seq_err),
        .err_wdog               (err_wdog)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Core model: latch rises 40 edges after key_ld, cipher_done pulses 41 cycles after enc_start.
    logic [5:0] kcnt, ecnt;
    logic       core_resp_en = 1'b1;
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            kcnt <= 6'd0;
            ecnt <= 6'd0;
            key_process_done_latch <= 1'b0;
        end else begin
            if (key_ld) begin
                kcnt <= 6'd40;
                key_process_done_latch <= 1'b0;
            end else if (kcnt != 6'd0) begin
                kcnt <= kcnt - 6'd1;
                if (kcnt == 6'd1) key_process_done_latch <= 1'b1;
            end
            if (enc_start && core_resp_en) ecnt <= 6'd41;
            else if (ecnt != 6'd0) ecnt <= ecnt - 6'd1;
        end
    end
    assign cipher_done = (ecnt == 6'd1);

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: kind 0 = key_ld, 1 = enc_start, 2 = seq_err
    typedef struct packed {
        logic [1:0]   kind;
        logic [127:0] val;
    } ev_t;
    ev_t exp_q[$];

    task automatic push_ev(input logic [1:0] k, input logic [127:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic mon_pop(input logic [1:0] k, input logic [127:0] v);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, none expected", k, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", {126'd0, k}, {126'd0, e.kind});
            if (e.kind != 2'd2) chk("event_block", v, e.val);
        end
    endtask

    always @(negedge clk_i) begin
        if (reset_n) begin
            if (key_ld)    mon_pop(2'd0, key_in);
            if (enc_start) mon_pop(2'd1, data_in);
            if (seq_err)   mon_pop(2'd2, 128'd0);
        end
    end

    // Called at #1 after a posedge; leaves s_valid high at #1 after the accepting edge.
    task automatic send_word(input logic [31:0] w, input logic k);
        int t;
        t = 0;
        s_word   = w;
        s_is_key = k;
        s_valid  = 1'b1;
        while (!s_ready && t < 200) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        if (t >= 200) chk("s_ready_timeout", {127'd0, s_ready}, 128'd1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_block(input logic [127:0] b, input logic k);
        send_word(b[127:96], k);
        send_word(b[95:64], k);
        send_word(b[63:32], k);
        send_word(b[31:0], k);
        s_valid = 1'b0;
    endtask

    task automatic wait_key_ready(output int at);
        int t;
        t = 0;
        while (!key_ready && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        at = cyc;
    endtask

    task automatic wait_enc(output int at);
        int t;
        t = 0;
        @(negedge clk_i);
        while (!enc_start && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        at = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    localparam logic [127:0] Key  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] Dat1 = {4{32'h11111111}};
    localparam logic [127:0] Dat2 = {4{32'h22222222}};
    localparam logic [127:0] Dat3 = {4{32'h33333333}};
    localparam logic [127:0] Dat4 = {4{32'h44444444}};
    localparam logic [127:0] Dat5 = {4{32'h55555555}};
    localparam logic [127:0] DatM = 128'hA0A0A0A0B1B1B1B1C2C2C2C2D3D3D3D3;

    initial begin
        int t0, t1, c1, c2, c3;

        // Reset values
        #2;
        chk("rst_s_ready", {127'd0, s_ready}, 128'd1);
        chk("rst_key_ld", {127'd0, key_ld}, 128'd0);
        chk("rst_enc_start", {127'd0, enc_start}, 128'd0);
        chk("rst_key_ready", {127'd0, key_ready}, 128'd0);
        chk("rst_seq_err", {127'd0, seq_err}, 128'd0);
        chk("rst_err_wdog", {127'd0, err_wdog}, 128'd0);
        chk("rst_key_in", key_in, 128'd0);
        chk("rst_data_in", data_in, 128'd0);
        @(negedge clk_i);
        reset_n = 1'b1;
        idle(1);

        // Key load and expansion latency
        push_ev(2'd0, Key);
        send_block(Key, 1'b1);
        t0 = cyc;
        chk("key_ld_latency", {127'd0, key_ld}, 128'd1);
        wait_key_ready(t1);
        chk("key_ready_delay", 128'(t1 - t0), 128'd42);

        // Two back-to-back data blocks, then a third that must stall at word 3
        @(posedge clk_i);
        #1;
        push_ev(2'd1, Dat1);
        push_ev(2'd1, Dat2);
        push_ev(2'd1, Dat3);
        send_word(32'h11111111, 1'b0);
        send_word(32'h11111111, 1'b0);
        send_word(32'h11111111, 1'b0);
        send_word(32'h11111111, 1'b0);
        c1 = cyc;
        chk("enc1_issue", {127'd0, enc_start}, 128'd1);
        for (int i = 0; i < 4; i++) send_word(32'h22222222, 1'b0);
        chk("pend_full_s_ready", {127'd0, s_ready}, 128'd1);
        for (int i = 0; i < 3; i++) send_word(32'h33333333, 1'b0);
        s_valid = 1'b0;
        chk("stall_s_ready", {127'd0, s_ready}, 128'd0);
        wait_enc(c2);
        chk("enc2_spacing", 128'(c2 - c1), 128'd42);
        send_word(32'h33333333, 1'b0);
        s_valid = 1'b0;
        wait_enc(c3);
        chk("enc3_spacing", 128'(c3 - c2), 128'd42);
        idle(50);

        // Reset in the 20th cycle of ENC_WAIT
        push_ev(2'd1, Dat4);
        send_block(Dat4, 1'b0);
        chk("enc4_issue", {127'd0, enc_start}, 128'd1);
        repeat (20) @(negedge clk_i);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_key_ready", {127'd0, key_ready}, 128'd0);
        chk("mid_rst_s_ready", {127'd0, s_ready}, 128'd1);
        chk("mid_rst_data_in", data_in, 128'd0);
        chk("mid_rst_enc_start", {127'd0, enc_start}, 128'd0);
        repeat (3) @(negedge clk_i);
        reset_n = 1'b1;
        idle(1);

        // Data block with no key loaded: dropped with one seq_err
        push_ev(2'd2, 128'd0);
        send_block(Dat5, 1'b0);
        idle(4);
        chk("drop_s_ready", {127'd0, s_ready}, 128'd1);
        chk("drop_key_ready", {127'd0, key_ready}, 128'd0);

        // Reload key, then key/key/data tag mismatch restarts the block at the data word
        push_ev(2'd0, Key);
        send_block(Key, 1'b1);
        t0 = cyc;
        wait_key_ready(t1);
        chk("key_ready_delay2", 128'(t1 - t0), 128'd42);
        @(posedge clk_i);
        #1;
        push_ev(2'd2, 128'd0);
        send_word(32'hDEAD0001, 1'b1);
        send_word(32'hDEAD0002, 1'b1);
        send_word(32'hA0A0A0A0, 1'b0);
        push_ev(2'd1, DatM);
        send_word(32'hB1B1B1B1, 1'b0);
        send_word(32'hC2C2C2C2, 1'b0);
        send_word(32'hD3D3D3D3, 1'b0);
        s_valid = 1'b0;
        chk("mismatch_enc_issue", {127'd0, enc_start}, 128'd1);
        idle(50);

`ifdef GIFT_IN_CTRL_WDOG_EN
        // Core never answers: watchdog fires 63 cycles into ENC_WAIT
        core_resp_en = 1'b0;
        push_ev(2'd1, Dat1);
        send_block(Dat1, 1'b0);
        t0 = cyc;
        begin
            int t;
            t = 0;
            while (!err_wdog && t < 100) begin
                @(negedge clk_i);
                t++;
            end
        end
        chk("wdog_delay", 128'(cyc - t0), 128'd64);
        chk("wdog_key_ready", {127'd0, key_ready}, 128'd0);
        core_resp_en = 1'b1;
        idle(1);
        push_ev(2'd2, 128'd0);
        send_block(Dat2, 1'b0);
        idle(4);
        chk("wdog_sticky", {127'd0, err_wdog}, 128'd1);
`else
        chk("no_wdog_err", {127'd0, err_wdog}, 128'd0);
`endif

        idle(5);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
